// File: rtl/gpiov2_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpiov2_ctrl_pkg
// Description : Shared constants for the gpiov2 pad controller. It holds the
//               configuration word layout, the reset configuration, the
//               drive-mode encodings and the shift-count state type.
// Revision    : 1.0 - initial release
// ============================================================================
package gpiov2_ctrl_pkg;

    localparam int CFG_W = 13;
    localparam logic [CFG_W-1:0] CFG_INIT = 13'h403;

    // Configuration word bit positions
    localparam int IDX_DM_HI   = 12;
    localparam int IDX_DM_LO   = 10;
    localparam int IDX_VTRIP   = 9;
    localparam int IDX_SLOW    = 8;
    localparam int IDX_ANA_POL = 7;
    localparam int IDX_ANA_SEL = 6;
    localparam int IDX_ANA_EN  = 5;
    localparam int IDX_IB_MODE = 4;
    localparam int IDX_INP_DIS = 3;
    localparam int IDX_HLD_OVR = 2;
    localparam int IDX_OE_OVR  = 1;
    localparam int IDX_MGMT_EN = 0;

    // Pad drive-mode encodings (dm[2:0])
    localparam logic [2:0] DM_HIZ          = 3'b000;
    localparam logic [2:0] DM_INPUT_ONLY   = 3'b001;
    localparam logic [2:0] DM_STRONG0_WK1  = 3'b010;
    localparam logic [2:0] DM_OPEN_DRAIN   = 3'b011;
    localparam logic [2:0] DM_OPEN_SOURCE  = 3'b100;
    localparam logic [2:0] DM_STRONG       = 3'b101;
    localparam logic [2:0] DM_WK0_STRONG1  = 3'b110;
    localparam logic [2:0] DM_STRONG_SLOW  = 3'b111;

    // Progress of the serial shift since the last load
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2,
        ST_OVER    = 2'd3
    } cnt_state_t;

endpackage : gpiov2_ctrl_pkg
`default_nettype wire

// File: rtl/gpiov2_ctrl_sync2.sv
`default_nettype none
// ============================================================================
// Module      : gpiov2_ctrl_sync2
// Description : Two-flop synchroniser for an asynchronous pad input.
// Ports       : i_clk    - core clock
//               i_resetn - asynchronous active-low reset
//               i_d      - asynchronous input
//               o_q      - synchronised output, two cycles of latency
// Revision    : 1.0 - initial release
// ============================================================================
module gpiov2_ctrl_sync2
    import gpiov2_ctrl_pkg::*;
(
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule : gpiov2_ctrl_sync2
`default_nettype wire

// File: rtl/sky130_fd_io__gpiov2_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sky130_fd_io__gpiov2_ctrl
// Description : Core-side controller for one gpiov2 pad. The configuration
//               word is shifted in MSB first through a daisy chain and made
//               active with a load strobe. The controller muxes management
//               or user output/enable onto the pad and returns the
//               synchronised pad input to the current owner.
// Ports       : i_clk, i_resetn              - clock, async active-low reset
//               i_serial_shift/_data_in/_load - serial configuration path
//               o_serial_data_out            - to next controller in chain
//               o_load_ok, o_load_err        - load status (pulse / sticky)
//               i_mgmt_*, i_user_*           - owner output data / enable
//               o_mgmt_in, o_user_in         - synchronised pad input
//               i_pad_in, o_pad_*            - pad-side pins
// Revision    : 1.0 - initial release
// ============================================================================
module sky130_fd_io__gpiov2_ctrl #(
    parameter int              CFG_W    = gpiov2_ctrl_pkg::CFG_W,
    parameter logic [12:0]     CFG_INIT = gpiov2_ctrl_pkg::CFG_INIT
) (
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_serial_shift,
    input  logic       i_serial_data_in,
    input  logic       i_serial_load,
    output logic       o_serial_data_out,
    output logic       o_load_ok,
    output logic       o_load_err,
    input  logic       i_mgmt_out,
    input  logic       i_mgmt_oe_n,
    input  logic       i_user_out,
    input  logic       i_user_oe_n,
    output logic       o_mgmt_in,
    output logic       o_user_in,
    input  logic       i_pad_in,
    output logic       o_pad_out,
    output logic       o_pad_oe_n,
    output logic [2:0] o_pad_dm,
    output logic       o_pad_vtrip_sel,
    output logic       o_pad_slow,
    output logic       o_pad_analog_pol,
    output logic       o_pad_analog_sel,
    output logic       o_pad_analog_en,
    output logic       o_pad_ib_mode_sel,
    output logic       o_pad_inp_dis,
    output logic       o_pad_hld_ovr
);

    import gpiov2_ctrl_pkg::*;

    // Counter runs 0..CFG_W+1; CFG_W+1 marks an over-long shift.
    localparam int               CNT_W      = $clog2(CFG_W + 2);
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(CFG_W);
    localparam logic [CNT_W-1:0] c_cnt_over = CNT_W'(CFG_W + 1);

    logic [CFG_W-1:0] r_cfg,      w_cfg_nxt;
    logic [CFG_W-1:0] r_shadow,   w_shadow_nxt;
    logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
    cnt_state_t       r_state,    w_state_nxt;
    logic             r_load_ok,  w_load_ok_nxt;
    logic             r_load_err, w_load_err_nxt;
    logic             w_sync;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_cfg      <= CFG_INIT;
            r_shadow   <= '0;
            r_cnt      <= '0;
            r_state    <= ST_EMPTY;
            r_load_ok  <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_cfg      <= w_cfg_nxt;
            r_shadow   <= w_shadow_nxt;
            r_cnt      <= w_cnt_nxt;
            r_state    <= w_state_nxt;
            r_load_ok  <= w_load_ok_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

    always_comb begin
        w_cfg_nxt      = r_cfg;
        w_shadow_nxt   = r_shadow;
        w_cnt_nxt      = r_cnt;
        w_state_nxt    = r_state;
        w_load_ok_nxt  = 1'b0;
        w_load_err_nxt = r_load_err;

        // A load takes priority; a simultaneous shift is dropped so the
        // loaded word is exactly the one that was counted in.
        if (i_serial_load) begin
            if (r_state == ST_FULL) begin
                w_cfg_nxt     = r_shadow;
                w_load_ok_nxt = 1'b1;
            end else begin
                w_load_err_nxt = 1'b1;
            end
            w_cnt_nxt   = '0;
            w_state_nxt = ST_EMPTY;
        end else if (i_serial_shift) begin
            w_shadow_nxt = {r_shadow[CFG_W-2:0], i_serial_data_in};
            if (r_state != ST_OVER) begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            if (w_cnt_nxt == c_cnt_full) begin
                w_state_nxt = ST_FULL;
            end else if (w_cnt_nxt == c_cnt_over) begin
                w_state_nxt = ST_OVER;
            end else begin
                w_state_nxt = ST_FILLING;
            end
        end
    end

    gpiov2_ctrl_sync2 u_sync (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_d      (i_pad_in),
        .o_q      (w_sync)
    );

    assign o_serial_data_out = r_shadow[CFG_W-1];
    assign o_load_ok         = r_load_ok;
    assign o_load_err        = r_load_err;

    assign o_pad_out  = r_cfg[IDX_MGMT_EN] ? i_mgmt_out : i_user_out;
    assign o_pad_oe_n = r_cfg[IDX_OE_OVR] |
                        (r_cfg[IDX_MGMT_EN] ? i_mgmt_oe_n : i_user_oe_n);

    assign o_mgmt_in  =  r_cfg[IDX_MGMT_EN] & ~r_cfg[IDX_INP_DIS] & w_sync;
    assign o_user_in  = ~r_cfg[IDX_MGMT_EN] & ~r_cfg[IDX_INP_DIS] & w_sync;

    assign o_pad_dm          = r_cfg[IDX_DM_HI:IDX_DM_LO];
    assign o_pad_vtrip_sel   = r_cfg[IDX_VTRIP];
    assign o_pad_slow        = r_cfg[IDX_SLOW];
    assign o_pad_analog_pol  = r_cfg[IDX_ANA_POL];
    assign o_pad_analog_sel  = r_cfg[IDX_ANA_SEL];
    assign o_pad_analog_en   = r_cfg[IDX_ANA_EN];
    assign o_pad_ib_mode_sel = r_cfg[IDX_IB_MODE];
    assign o_pad_inp_dis     = r_cfg[IDX_INP_DIS];
    assign o_pad_hld_ovr     = r_cfg[IDX_HLD_OVR];

endmodule : sky130_fd_io__gpiov2_ctrl
`default_nettype wire

// File: tb/tb_sky130_fd_io__gpiov2_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sky130_fd_io__gpiov2_ctrl
// Description : Directed self-checking bench for the gpiov2 pad controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sky130_fd_io__gpiov2_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       shift, sdi, load;
    logic       sdo, load_ok, load_err;
    logic       mgmt_out, mgmt_oe_n, user_out, user_oe_n;
    logic       mgmt_in, user_in, pad_in;
    logic       pad_out, pad_oe_n;
    logic [2:0] pad_dm;
    logic       vtrip, slow, apol, asel, aen, ibm, inpdis, hld;
    logic [7:0] misc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign misc = {vtrip, slow, apol, asel, aen, ibm, inpdis, hld};

    sky130_fd_io__gpiov2_ctrl dut (
        .i_clk             (clk),
        .i_resetn          (resetn),
        .i_serial_shift    (shift),
        .i_serial_data_in  (sdi),
        .i_serial_load     (load),
        .o_serial_data_out (sdo),
        .o_load_ok         (load_ok),
        .o_load_err        (load_err),
        .i_mgmt_out        (mgmt_out),
        .i_mgmt_oe_n       (mgmt_oe_n),
        .i_user_out        (user_out),
        .i_user_oe_n       (user_oe_n),
        .o_mgmt_in         (mgmt_in),
        .o_user_in         (user_in),
        .i_pad_in          (pad_in),
        .o_pad_out         (pad_out),
        .o_pad_oe_n        (pad_oe_n),
        .o_pad_dm          (pad_dm),
        .o_pad_vtrip_sel   (vtrip),
        .o_pad_slow        (slow),
        .o_pad_analog_pol  (apol),
        .o_pad_analog_sel  (asel),
        .o_pad_analog_en   (aen),
        .o_pad_ib_mode_sel (ibm),
        .o_pad_inp_dis     (inpdis),
        .o_pad_hld_ovr     (hld)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic shift_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sdi   = val[i];
            shift = 1'b1;
            tick();
        end
        shift = 1'b0;
        sdi   = 1'b0;
    endtask

    task automatic do_load();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    logic [19:0] pat;
    logic        exp_bit;

    initial begin
        resetn = 1'b0; shift = 1'b0; sdi = 1'b0; load = 1'b0;
        mgmt_out = 1'b0; mgmt_oe_n = 1'b0; user_out = 1'b0; user_oe_n = 1'b0;
        pad_in = 1'b0;
        pat = 20'hA5C3B;

        // ---- reset state ----
        tick();
        tick();
        check("rst_dm",      32'(pad_dm),   32'h1);
        check("rst_oe_n",    32'(pad_oe_n), 32'h1);
        check("rst_mgmt_in", 32'(mgmt_in),  32'h0);
        check("rst_user_in", 32'(user_in),  32'h0);
        check("rst_sdo",     32'(sdo),      32'h0);
        check("rst_err",     32'(load_err), 32'h0);
        check("rst_ok",      32'(load_ok),  32'h0);
        check("rst_misc",    32'(misc),     32'h0);
        resetn = 1'b1;
        tick();

        // ---- valid load 13'h1C12: dm=111, ib_mode=1, oe_ovr=1, user owner ----
        shift_bits(32'h1C12, 13);
        check("t1_sdo_msb", 32'(sdo), 32'h1);
        do_load();
        check("t1_ok",      32'(load_ok),  32'h1);
        check("t1_dm",      32'(pad_dm),   32'h7);
        check("t1_misc",    32'(misc),     32'h04);
        check("t1_err",     32'(load_err), 32'h0);
        tick();
        check("t1_ok_pulse", 32'(load_ok), 32'h0);
        user_out = 1'b1; mgmt_out = 1'b0; #1;
        check("t1_out_user1", 32'(pad_out), 32'h1);
        user_out = 1'b0; mgmt_out = 1'b1; #1;
        check("t1_out_user0", 32'(pad_out), 32'h0);
        user_oe_n = 1'b0; mgmt_oe_n = 1'b0; #1;
        check("t1_oe_ovr", 32'(pad_oe_n), 32'h1);
        pad_in = 1'b1;
        tick();
        check("t1_uin_lat1", 32'(user_in), 32'h0);
        tick();
        check("t1_uin_lat2", 32'(user_in), 32'h1);
        check("t1_min",      32'(mgmt_in), 32'h0);
        pad_in = 1'b0;
        tick();
        tick();

        // ---- short shift (12) then load, then a valid load ----
        do_reset();
        shift_bits(32'hFFF, 12);
        do_load();
        check("t2_err",     32'(load_err), 32'h1);
        check("t2_ok",      32'(load_ok),  32'h0);
        check("t2_dm_keep", 32'(pad_dm),   32'h1);
        // 13'h0A01: dm=010, vtrip=1, mgmt owner, no override
        shift_bits(32'h0A01, 13);
        do_load();
        check("t2_ok2",     32'(load_ok),  32'h1);
        check("t2_err_stk", 32'(load_err), 32'h1);
        check("t2_dm2",     32'(pad_dm),   32'h2);
        check("t2_misc",    32'(misc),     32'h80);
        mgmt_out = 1'b1; user_out = 1'b0; mgmt_oe_n = 1'b0; user_oe_n = 1'b1; #1;
        check("t2_out_mgmt", 32'(pad_out),  32'h1);
        check("t2_oe_mgmt",  32'(pad_oe_n), 32'h0);
        mgmt_oe_n = 1'b1; #1;
        check("t2_oe_mgmt1", 32'(pad_oe_n), 32'h1);

        // ---- over-long shift (20) with chain output tracking ----
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            sdi   = pat[20 - n];
            shift = 1'b1;
            tick();
            exp_bit = (n >= 13) ? pat[20 - (n - 12)] : 1'b0;
            check($sformatf("t3_sdo_%0d", n), 32'(sdo), 32'(exp_bit));
        end
        shift = 1'b0;
        sdi   = 1'b0;
        do_load();
        check("t3_err", 32'(load_err), 32'h1);
        check("t3_dm",  32'(pad_dm),   32'h1);
        check("t3_ok",  32'(load_ok),  32'h0);

        // ---- shift and load together with 13 bits counted ----
        do_reset();
        shift_bits(32'h0C03, 13);
        shift = 1'b1; sdi = 1'b1;
        do_load();
        shift = 1'b0; sdi = 1'b0;
        check("t4_ok",  32'(load_ok), 32'h1);
        check("t4_dm",  32'(pad_dm),  32'h3);
        check("t4_sdo", 32'(sdo),     32'h0);
        // count restarted from zero: 12 more shifts is short
        shift_bits(32'h0, 12);
        do_load();
        check("t4_cnt0", 32'(load_err), 32'h1);

        // ---- mgmt owner input path at reset config ----
        do_reset();
        pad_in = 1'b1;
        tick();
        check("t5_min_lat1", 32'(mgmt_in), 32'h0);
        tick();
        check("t5_min_lat2", 32'(mgmt_in), 32'h1);
        check("t5_uin",      32'(user_in), 32'h0);
        pad_in = 1'b0;
        tick();
        tick();
        check("t5_min_fall", 32'(mgmt_in), 32'h0);

        // ---- field patterns 0x0154 / 0x02A8 (the latter sets inp_dis) ----
        shift_bits(32'h0154, 13);
        do_load();
        check("t6_misc55", 32'(misc),   32'h55);
        check("t6_dm0",    32'(pad_dm), 32'h0);
        shift_bits(32'h02A8, 13);
        do_load();
        check("t6_miscAA", 32'(misc),   32'hAA);
        pad_in = 1'b1;
        tick(); tick(); tick();
        check("t6_inpdis_m", 32'(mgmt_in), 32'h0);
        check("t6_inpdis_u", 32'(user_in), 32'h0);
        pad_in = 1'b0;

        // ---- reset in the middle of a shift ----
        do_reset();
        shift_bits(32'h7F, 7);
        resetn = 1'b0;
        #2;
        check("t7_dm",  32'(pad_dm),   32'h1);
        check("t7_err", 32'(load_err), 32'h0);
        tick();
        resetn = 1'b1;
        tick();
        // six ones would complete 13 only if the partial count survived
        shift_bits(32'h3F, 6);
        check("t7_sdo", 32'(sdo), 32'h0);
        do_load();
        check("t7_short", 32'(load_err), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sky130_fd_io__gpiov2_ctrl
`default_nettype wire
